instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the 16-bit instruction decoder: packs instruction fields into a 16-bit instruction word for the core's instruction memory.
- Sits between a loader/debug front-end and the imem write port.
- Field tuples arrive over a valid/ready handshake, are range-checked, encoded, and buffered in a small FIFO.
- Words leave with an auto-incrementing imem write address.

Parameters:
- FIFO_DEPTH, 2, number of encoded-word entries buffered (power of 2, >=2)
- ADDR_W, 8, width of imem write address
- BASE_ADDR, 0, address assigned to the first word after reset/flush

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- flush  input  1  synchronous clear: empty FIFO, reload address, clear error
- in_valid  input  1  field tuple valid
- in_ready_o  output  1  encoder can accept tuple
- op  input  3  opcode (riscv_pkg opcode_t value)
- rd  input  3  destination register
- rs1_addr  input  3  source register 1
- rs2_addr  input  3  source register 2
- func4  input  4  R-type extended opcode
- func2  input  3  I/L/S/B qualifier
- imm  input  6  immediate, two's complement
- out_valid_o  output  1  encoded word available
- out_ready  input  1  consumer takes word
- instr_o  output  16  encoded instruction at FIFO head
- addr_o  output  ADDR_W  imem address for instr_o
- err_o  output  1  sticky: at least one tuple rejected
- count_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n=0 at clk edge) values:
  - out_valid_o=0, in_ready_o=1 from the next cycle, instr_o=0, addr_o=BASE_ADDR, err_o=0, count_o=0.
  - FIFO pointers cleared.
- Encoding: instr[2:0]=op in all cases.
  - R_OP: [5:3]=rd, [8:6]=rs1, [11:9]=rs2, [15:12]=func4.
  - I_OP, L_OP: [5:3]=rd, [8:6]=rs1, [11:9]=func2, [15:12]=imm[3:0].
  - S_OP, B_OP: [5:3]=rs2, [8:6]=rs1, [11:9]=func2, [15:12]=imm[3:0].
  - J_OP: [5:3]=rd, [9:6]=0, [15:10]=imm[5:0].
  - Unused input fields are ignored.
- Legality:
  - For I/L/S/B, imm must be sign-representable in 4 bits: imm[5:3] all equal, range -8..7.
  - Any op not in {R,I,L,S,B,J} is illegal.
  - An illegal tuple is still handshaken (consumed) but not pushed; err_o sets the next cycle and holds until flush or reset.
- Handshake:
  - in_ready_o = (count < FIFO_DEPTH). No full-bypass: a pop does not raise in_ready_o in the same cycle.
  - Push occurs on in_valid & in_ready_o & legal.
  - A tuple accepted at edge N gives out_valid_o=1 after edge N, when the FIFO was empty. This is 1-cycle latency.
  - Pop occurs on out_valid_o & out_ready.
  - instr_o, addr_o, out_valid_o are stable while out_valid_o=1 and out_ready=0.
  - in_ready_o is independent of in_valid.
- Address:
  - addr_o is a counter incremented on each pop. It wraps from 2^ADDR_W-1 to 0, not to BASE_ADDR.
  - Rejected tuples do not consume an address.
- Simultaneous push and pop: occupancy unchanged, both take effect.
- Empty: out_valid_o=0; out_ready is ignored.
- Full: in_ready_o=0; in_valid is ignored.
- Flush:
  - Has priority over push/pop in the same cycle; the tuple offered that cycle is discarded.
  - Next cycle state equals reset state.
- Reset mid-operation: all buffered words are lost; no partial outputs.

Optional Feature:
- Macro INSTR_ENC_PARITY_EN.
- When defined:
  - Each FIFO entry stores an extra even-parity bit (XOR of the 16 instruction bits).
  - Output port parity_o (1 bit) accompanies instr_o; its reset value is 0.
- When undefined:
  - The parity_o port and its storage do not exist.
  - All other behaviour is identical.

Test Plan:
- R_OP, rd=3, rs1=5, rs2=6, func4=4'hA, out_ready=1 -> one cycle later out_valid_o=1, instr_o=16'hAD58|R_OP, addr_o=BASE_ADDR; the next pop shows addr BASE_ADDR+1.
- I_OP, rd=1, rs1=2, func2=0, imm=6'h3D (-3) -> instr_o=16'hD088|I_OP. J_OP, rd=7, imm=6'h2B -> instr_o=16'hAC38|J_OP.
- I_OP with imm=6'h08 (+8), and op outside the enum -> each tuple is consumed (in_ready_o=1), nothing is pushed, err_o=1 and stays 1; addr not advanced; flush clears err_o.
- out_ready=0, push FIFO_DEPTH legal tuples -> in_ready_o=0, count_o=FIFO_DEPTH, instr_o held. Then raise out_ready with concurrent in_valid -> FIFO order preserved, in_ready_o returns the cycle after the first pop.
- Preload the address counter to 2^ADDR_W-1 via pops (ADDR_W=3) -> the next word gets addr_o=0. Flush with full FIFO and in_valid=1 -> next cycle count_o=0, addr_o=BASE_ADDR, the offered tuple is dropped.
- rst_n=0 for one edge while the FIFO is full -> out_valid_o=0, count_o=0, err_o=0. With INSTR_ENC_PARITY_EN, parity_o=^instr_o for every output word.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs decoded instruction fields into 16-bit instruction words, buffers them
//   in a small FIFO and presents each word with an auto-incrementing imem
//   write address.
//
//   Optional build macro: INSTR_ENC_PARITY_EN adds an even-parity bit per entry
//   and the parity_o output port.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   flush            synchronous clear (FIFO emptied, address reloaded, error cleared)
//   in_valid         field tuple valid          in_ready_o  encoder can accept tuple
//   op, rd, rs1_addr, rs2_addr, func4, func2, imm   instruction fields
//   out_valid_o      word available             out_ready   consumer takes word
//   instr_o          encoded word at FIFO head  addr_o      imem address for instr_o
//   err_o            sticky rejected-tuple flag count_o     FIFO occupancy
//   parity_o         (INSTR_ENC_PARITY_EN only) even parity of instr_o
module instr_encoder #(
    parameter int unsigned       FIFO_DEPTH = 2,
    parameter int unsigned       ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready_o,
    input  logic [2:0]                    op,
    input  logic [2:0]                    rd,
    input  logic [2:0]                    rs1_addr,
    input  logic [2:0]                    rs2_addr,
    input  logic [3:0]                    func4,
    input  logic [2:0]                    func2,
    input  logic [5:0]                    imm,
    output logic                          out_valid_o,
    input  logic                          out_ready,
    output logic [15:0]                   instr_o,
    output logic [ADDR_W-1:0]             addr_o,
    output logic                          err_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
`ifdef INSTR_ENC_PARITY_EN
    ,
    output logic                          parity_o
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
`ifdef INSTR_ENC_PARITY_EN
    localparam int unsigned DW = 17;
`else
    localparam int unsigned DW = 16;
`endif

    typedef enum logic [2:0] {
        R_OP = 3'd0,
        I_OP = 3'd1,
        L_OP = 3'd2,
        S_OP = 3'd3,
        B_OP = 3'd4,
        J_OP = 3'd5
    } opcode_t;

    logic [DW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] addr;
    logic              err;

    logic [15:0]       enc;
    logic [DW-1:0]     wdata;
    logic              legal;
    logic              imm_ok;
    logic              take;
    logic              push;
    logic              pop;
    logic              clr;

    // Field packing and legality check
    always_comb begin
        enc    = '0;
        legal  = 1'b0;
        imm_ok = (imm[5:3] == 3'b000) || (imm[5:3] == 3'b111);
        case (opcode_t'(op))
            R_OP: begin
                enc   = {func4, rs2_addr, rs1_addr, rd, op};
                legal = 1'b1;
            end
            I_OP, L_OP: begin
                enc   = {imm[3:0], func2, rs1_addr, rd, op};
                legal = imm_ok;
            end
            S_OP, B_OP: begin
                enc   = {imm[3:0], func2, rs1_addr, rs2_addr, op};
                legal = imm_ok;
            end
            J_OP: begin
                enc   = {imm, 4'b0000, rd, op};
                legal = 1'b1;
            end
            default: begin
                enc   = '0;
                legal = 1'b0;
            end
        endcase
    end

`ifdef INSTR_ENC_PARITY_EN
    assign wdata = {^enc, enc};
`else
    assign wdata = enc;
`endif

    // in_ready_o comes straight from the registered count, so a pop never
    // frees a slot for a push in the same cycle.
    assign in_ready_o  = (count < CW'(FIFO_DEPTH));
    assign out_valid_o = (count != '0);
    assign clr         = !rst_n || flush;
    assign take        = in_valid && in_ready_o && !clr;
    assign push        = take && legal;
    assign pop         = out_valid_o && out_ready && !clr;

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            addr   <= BASE_ADDR;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                addr   <= addr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (take && !legal) begin
                err <= 1'b1;
            end
        end
    end

    // Storage needs no reset; entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign instr_o = out_valid_o ? mem[rd_ptr][15:0] : '0;
    assign addr_o  = addr;
    assign err_o   = err;
    assign count_o = count;
`ifdef INSTR_ENC_PARITY_EN
    assign parity_o = out_valid_o ? mem[rd_ptr][16] : 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 3;
    localparam int unsigned BASE  = 2;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [3:0] func4;
        logic [2:0] func2;
        logic [5:0] imm;
    } tup_t;

    typedef struct {
        tup_t        t;
        logic [15:0] exp;
        bit          legal;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready_o;
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1_addr;
    logic [2:0]  rs2_addr;
    logic [3:0]  func4;
    logic [2:0]  func2;
    logic [5:0]  imm;
    logic        out_valid_o;
    logic        out_ready;
    logic [15:0] instr_o;
    logic [AW-1:0] addr_o;
    logic        err_o;
    logic [$clog2(DEPTH):0] count_o;
`ifdef INSTR_ENC_PARITY_EN
    logic        parity_o;
`endif

    instr_encoder #(
        .FIFO_DEPTH(DEPTH),
        .ADDR_W    (AW),
        .BASE_ADDR (3'(BASE))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready_o (in_ready_o),
        .op         (op),
        .rd         (rd),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .func4      (func4),
        .func2      (func2),
        .imm        (imm),
        .out_valid_o(out_valid_o),
        .out_ready  (out_ready),
        .instr_o    (instr_o),
        .addr_o     (addr_o),
        .err_o      (err_o),
        .count_o    (count_o)
`ifdef INSTR_ENC_PARITY_EN
        ,
        .parity_o   (parity_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model state
    logic [15:0] mq[$];
    int unsigned maddr = BASE;
    bit          merr  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding computed from the field positions as weighted sums.
    function automatic logic [15:0] ref_enc(input tup_t t, output bit legal);
        int unsigned o, d, s1, s2, f4, f2, iu, v;
        int          si;
        o  = t.op;  d  = t.rd;  s1 = t.rs1; s2 = t.rs2;
        f4 = t.func4; f2 = t.func2; iu = t.imm;
        si = $signed(t.imm);
        v  = 0;
        legal = 0;
        case (o)
            0: begin v = o + d*8 + s1*64 + s2*512 + f4*4096; legal = 1; end
            1, 2: begin
                v = o + d*8 + s1*64 + f2*512 + (iu % 16)*4096;
                legal = (si >= -8) && (si <= 7);
            end
            3, 4: begin
                v = o + s2*8 + s1*64 + f2*512 + (iu % 16)*4096;
                legal = (si >= -8) && (si <= 7);
            end
            5: begin v = o + d*8 + iu*1024; legal = 1; end
            default: begin v = 0; legal = 0; end
        endcase
        return 16'(v);
    endfunction

    // One clock: drive inputs, advance the model, compare every output.
    task automatic cycle(input bit v, input bit ordy, input bit fl, input bit rn, input tup_t t);
        bit          lg;
        bit          rdy;
        logic [15:0] w;
        logic [15:0] head;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        op = t.op; rd = t.rd; rs1_addr = t.rs1; rs2_addr = t.rs2;
        func4 = t.func4; func2 = t.func2; imm = t.imm;
        w   = ref_enc(t, lg);
        rdy = mq.size() < DEPTH;
        if (!rn || fl) begin
            mq.delete();
            maddr = BASE;
            merr  = 0;
        end else begin
            if (mq.size() > 0 && ordy) begin
                void'(mq.pop_front());
                maddr = (maddr + 1) % (1 << AW);
            end
            if (v && rdy) begin
                if (lg) mq.push_back(w);
                else merr = 1;
            end
        end
        @(posedge clk);
        #1;
        head = (mq.size() > 0) ? mq[0] : 16'h0;
        chk("out_valid", 32'(out_valid_o), 32'(mq.size() > 0));
        chk("in_ready",  32'(in_ready_o),  32'(mq.size() < DEPTH));
        chk("count",     32'(count_o),     32'(mq.size()));
        chk("instr",     32'(instr_o),     32'(head));
        chk("addr",      32'(addr_o),      maddr);
        chk("err",       32'(err_o),       32'(merr));
`ifdef INSTR_ENC_PARITY_EN
        chk("parity",    32'(parity_o),    32'(^head));
`endif
    endtask

    function automatic tup_t mk(input logic [2:0] o, input logic [2:0] d, input logic [2:0] a,
                                input logic [2:0] b, input logic [3:0] f4, input logic [2:0] f2,
                                input logic [5:0] im);
        tup_t t;
        t.op = o; t.rd = d; t.rs1 = a; t.rs2 = b; t.func4 = f4; t.func2 = f2; t.imm = im;
        return t;
    endfunction

    vec_t        tbl[11];
    tup_t        idle;
    tup_t        tr;
    tup_t        ti;
    logic [31:0] r;

    initial begin
        idle = '0;
        tr   = mk(3'd0, 3'd3, 3'd5, 3'd6, 4'hA, 3'd0, 6'h00);
        ti   = mk(3'd1, 3'd1, 3'd2, 3'd0, 4'h0, 3'd0, 6'h3D);
        tbl[0]  = '{tr, 16'hAD58, 1};
        tbl[1]  = '{ti, 16'hD089, 1};
        tbl[2]  = '{mk(3'd5, 3'd7, 3'd0, 3'd0, 4'h0, 3'd0, 6'h2B), 16'hAC3D, 1};
        tbl[3]  = '{mk(3'd1, 3'd1, 3'd2, 3'd0, 4'h0, 3'd0, 6'h08), 16'h0000, 0};
        tbl[4]  = '{mk(3'd6, 3'd1, 3'd2, 3'd3, 4'h1, 3'd0, 6'h00), 16'h0000, 0};
        tbl[5]  = '{mk(3'd7, 3'd0, 3'd0, 3'd0, 4'h0, 3'd0, 6'h00), 16'h0000, 0};
        tbl[6]  = '{mk(3'd3, 3'd6, 3'd1, 3'd4, 4'h9, 3'd5, 6'h07), 16'h7A63, 1};
        tbl[7]  = '{mk(3'd4, 3'd0, 3'd7, 3'd7, 4'h0, 3'd7, 6'h38), 16'h8FFC, 1};
        tbl[8]  = '{mk(3'd2, 3'd2, 3'd3, 3'd5, 4'h0, 3'd1, 6'h3F), 16'hF2D2, 1};
        tbl[9]  = '{mk(3'd3, 3'd0, 3'd0, 3'd0, 4'h0, 3'd0, 6'h37), 16'h0000, 0};
        tbl[10] = '{mk(3'd5, 3'd0, 3'd3, 3'd3, 4'hF, 3'd7, 6'h20), 16'h8005, 1};

        // Reset state
        cycle(0, 0, 0, 0, idle);
        cycle(0, 0, 0, 0, idle);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_addr",  32'(addr_o),  BASE);
        cycle(0, 1, 0, 1, idle);

        // Encoding table, each from an empty FIFO
        foreach (tbl[i]) begin
            cycle(0, 0, 1, 1, idle);
            cycle(1, 0, 0, 1, tbl[i].t);
            chk("tbl_valid", 32'(out_valid_o), 32'(tbl[i].legal));
            chk("tbl_err",   32'(err_o),       32'(!tbl[i].legal));
            if (tbl[i].legal) chk("tbl_instr", 32'(instr_o), 32'(tbl[i].exp));
            cycle(0, 1, 0, 1, idle);
            chk("tbl_err_hold", 32'(err_o), 32'(!tbl[i].legal));
            chk("tbl_addr",     32'(addr_o), tbl[i].legal ? BASE + 1 : BASE);
        end

        // 1-cycle latency and address advance on pop
        cycle(0, 0, 1, 1, idle);
        chk("flush_err", 32'(err_o), 0);
        cycle(1, 1, 0, 1, tr);
        chk("lat_instr", 32'(instr_o), 32'hAD58);
        chk("lat_addr",  32'(addr_o),  BASE);
        cycle(1, 1, 0, 1, ti);
        chk("lat_addr2", 32'(addr_o),  BASE + 1);
        cycle(0, 1, 0, 1, idle);

        // Backpressure: fill, hold, then drain with concurrent offers
        cycle(0, 0, 1, 1, idle);
        cycle(1, 0, 0, 1, tr);
        cycle(1, 0, 0, 1, ti);
        cycle(1, 0, 0, 1, tbl[2].t);
        chk("full_ready", 32'(in_ready_o), 0);
        chk("full_instr", 32'(instr_o), 32'hAD58);
        cycle(1, 1, 0, 1, tbl[2].t);
        chk("drain_ready", 32'(in_ready_o), 1);
        chk("drain_instr", 32'(instr_o), 32'hD089);
        cycle(1, 1, 0, 1, tbl[2].t);
        chk("drain_order", 32'(instr_o), 32'hAC3D);
        cycle(0, 1, 0, 1, idle);
        cycle(0, 1, 0, 1, idle);

        // Address wrap: 2..7 then 0, not back to base
        cycle(0, 0, 1, 1, idle);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 1, tr);
            cycle(0, 1, 0, 1, idle);
        end
        chk("wrap_pre", 32'(addr_o), 7);
        cycle(1, 0, 0, 1, tr);
        cycle(1, 1, 0, 1, ti);
        chk("wrap_addr", 32'(addr_o), 0);
        chk("wrap_instr", 32'(instr_o), 32'hD089);

        // Flush with a full FIFO and an offered tuple
        cycle(1, 0, 0, 1, tr);
        cycle(1, 0, 1, 1, tr);
        chk("flush_count", 32'(count_o), 0);
        chk("flush_addr",  32'(addr_o),  BASE);

        // Reset while full with error set
        cycle(1, 0, 0, 1, tr);
        cycle(1, 0, 0, 1, tbl[3].t);
        cycle(1, 0, 0, 1, tr);
        cycle(1, 0, 0, 1, tr);
        chk("pre_rst_err", 32'(err_o), 1);
        cycle(1, 1, 0, 0, tr);
        chk("mid_rst_valid", 32'(out_valid_o), 0);
        chk("mid_rst_err",   32'(err_o), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tup_t t;
            bit   v, o, f, n;
            r = $urandom;
            t = r[23:0];
            v = ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 63) == 0);
            n = ($urandom_range(0, 127) != 0);
            cycle(v, o, f, n, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
